// File: rtl/ifetch_queue.sv
// Instruction fetch: fetch PC, 1-cycle synchronous ROM port, DEPTH-entry prefetch queue, redirect flush.
// Optional IFETCH_MISALIGN_EN: a misaligned redirect target yields one fault entry and halts fetch.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              ROM_AW   = 14,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_fault,
    output logic              rom_en,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [31:0]       rom_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]             fpc_q, fpc_d;
    logic [XLEN-1:0]             inflight_pc_q, inflight_pc_d;
    logic                        inflight_q, inflight_d;
    logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]               count_q, count_d;
    logic [DEPTH-1:0][XLEN-1:0]  mem_pc_q, mem_pc_d;
    logic [DEPTH-1:0][31:0]      mem_inst_q, mem_inst_d;
    logic [CW:0]                 occ;
    logic                        issue, push, pop, halted;

`ifdef IFETCH_MISALIGN_EN
    logic                        halt_q, halt_d;
    logic [DEPTH-1:0]            mem_fault_q, mem_fault_d;
    assign halted    = halt_q;
    assign out_fault = out_valid ? mem_fault_q[head_q] : 1'b0;
`else
    assign halted    = 1'b0;
    assign out_fault = 1'b0;
`endif

    assign rom_en   = issue;
    assign rom_addr = fpc_q[ROM_AW+1:2];
    assign out_pc   = out_valid ? mem_pc_q[head_q] : '0;
    assign out_inst = out_valid ? mem_inst_q[head_q] : '0;

    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        mem_pc_d      = mem_pc_q;
        mem_inst_d    = mem_inst_q;
`ifdef IFETCH_MISALIGN_EN
        halt_d        = halt_q;
        mem_fault_d   = mem_fault_q;
`endif
        out_valid = (count_q != '0);
        // The in-flight read reserves a slot so its return can never overflow the queue.
        occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue = !rst && !redirect_valid && !halted && (occ < (CW+1)'(DEPTH));
        push  = inflight_q;
        pop   = out_valid && out_ready;

        if (redirect_valid) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fpc_d      = redirect_pc & ~XLEN'(3);
`ifdef IFETCH_MISALIGN_EN
            halt_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                mem_pc_d[0]    = redirect_pc;
                mem_inst_d[0]  = 32'h0000_0013;
                mem_fault_d[0] = 1'b1;
                tail_d         = PW'(1);
                count_d        = CW'(1);
                halt_d         = 1'b1;
            end
`endif
        end else begin
            if (push) begin
                mem_pc_d[tail_q]   = inflight_pc_q;
                mem_inst_d[tail_q] = rom_data;
`ifdef IFETCH_MISALIGN_EN
                mem_fault_d[tail_q] = 1'b0;
`endif
                tail_d = tail_q + PW'(1);
            end
            if (pop) head_d = head_q + PW'(1);
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = issue;
            if (issue) begin
                inflight_pc_d = fpc_q;
                fpc_d         = fpc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
`ifdef IFETCH_MISALIGN_EN
            halt_q        <= 1'b0;
`endif
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
`ifdef IFETCH_MISALIGN_EN
            halt_q        <= halt_d;
`endif
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        mem_pc_q    <= mem_pc_d;
        mem_inst_q  <= mem_inst_d;
`ifdef IFETCH_MISALIGN_EN
        mem_fault_q <= mem_fault_d;
`endif
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: ROM[i]=i+100 model, scoreboard of expected pcs popped on each accepted handshake.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_inst, out_pc;
    logic        out_fault, rom_en;
    logic [13:0] rom_addr;
    logic [31:0] rom_data = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    bit          sb_en = 1'b1;
    logic [31:0] ep, ei;

    ifetch_queue dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .out_fault(out_fault), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= 32'(rom_addr) + 32'd100;

    // Scoreboard: every accepted handshake must match the oldest expected pc.
    always begin
        @(negedge clk);
        #2;
        if (sb_en && !rst && out_valid && out_ready && !redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: popped pc=%h, nothing expected", out_pc);
            end else begin
                ep = exp_q.pop_front();
                ei = ((ep >> 2) & 32'h3FFF) + 32'd100;
                if (out_pc !== ep || out_inst !== ei || out_fault !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_pop: got pc=%h inst=%h fault=%b, expected pc=%h inst=%h fault=0",
                             out_pc, out_inst, out_fault, ep, ei);
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset(input logic rdy);
        tick;
        rst = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        tick;
        tick;
        exp_q.delete();
        rst = 1'b0; out_ready = rdy;
    endtask

    task automatic test_reset;
        tick;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; out_ready = 1'b1;
        #1;
        checks++;
        if (rom_en !== 1'b0) begin errors++; $display("FAIL reset_rom_en: rom_en=%b expected 0", rom_en); end
        tick;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || out_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h inst=%h fault=%b expected all 0",
                     out_valid, out_pc, out_inst, out_fault);
        end
        tick;
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 14'h0) begin
            errors++;
            $display("FAIL reset_pc: rom_en=%b rom_addr=%h expected 1/0000", rom_en, rom_addr);
        end
    endtask

    task automatic test_stream;
        int first;
        first = -1;
        apply_reset(1'b1);
        for (int i = 0; i < 20; i++) exp_q.push_back(32'(i * 4));
        for (int c = 0; c < 22; c++) begin
            if (c > 0) tick;
            #1;
            if (out_valid && first < 0) first = c;
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap: cycle %0d out_valid=%b expected 1", c, out_valid);
                end
            end
        end
        #2;
        checks++;
        if (first != 2) begin errors++; $display("FAIL stream_latency: first valid cycle %0d expected 2", first); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stream_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_stall;
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick;
            #1;
            checks++;
            if (rom_en !== (c < 4)) begin
                errors++;
                $display("FAIL stall_rom_en: cycle %0d rom_en=%b expected %b", c, rom_en, (c < 4));
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
                    errors++;
                    $display("FAIL stall_head: cycle %0d valid=%b pc=%h expected 1/0", c, out_valid, out_pc);
                end
            end
        end
        tick;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #3;
            if (exp_q.size() == 0) break;
            tick;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect;
        apply_reset(1'b1);
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        for (int c = 1; c < 5; c++) tick;
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++;
        if (rom_en !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'hC) begin
            errors++;
            $display("FAIL redir_cycle: rom_en=%b valid=%b pc=%h expected 0/1/0000000c", rom_en, out_valid, out_pc);
        end
        tick;
        redirect_valid = 1'b0;
        exp_q.push_back(32'h200); exp_q.push_back(32'h204);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 14'h80) begin
            errors++;
            $display("FAIL redir_n1: valid=%b rom_en=%b addr=%h expected 0/1/0080", out_valid, rom_en, rom_addr);
        end
        tick;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_n2: valid=%b expected 0", out_valid); end
        tick;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            errors++;
            $display("FAIL redir_n3: valid=%b pc=%h expected 1/00000200", out_valid, out_pc);
        end
        tick;
        #3;
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL redir_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_full;
        apply_reset(1'b0);
        for (int c = 1; c < 8; c++) tick;
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h300; out_ready = 1'b1;
        tick;
        redirect_valid = 1'b0;
        exp_q.push_back(32'h300); exp_q.push_back(32'h304);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: valid=%b expected 0", out_valid); end
        for (int c = 0; c < 10; c++) begin
            tick;
            #3;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL flush_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_rst_mid;
        apply_reset(1'b0);
        for (int c = 1; c < 8; c++) tick;
        tick;
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h700; out_ready = 1'b1;
        tick;
        rst = 1'b0; redirect_valid = 1'b0;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        #1;
        checks++;
        if (out_valid !== 1'b0 || rom_en !== 1'b1 || rom_addr !== 14'h0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b rom_en=%b addr=%h expected 0/1/0000", out_valid, rom_en, rom_addr);
        end
        for (int c = 0; c < 10; c++) begin
            tick;
            #3;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rst_mid_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap;
        apply_reset(1'b0);
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 14'h3FFF) begin
            errors++;
            $display("FAIL wrap_addr: rom_en=%b addr=%h expected 1/3fff", rom_en, rom_addr);
        end
        for (int c = 0; c < 10; c++) begin
            tick;
            #3;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain: %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_misalign;
        apply_reset(1'b0);
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        #1;
        checks++;
        if (rom_en !== 1'b0) begin errors++; $display("FAIL mis_redir: rom_en=%b expected 0", rom_en); end
`ifdef IFETCH_MISALIGN_EN
        tick;
        redirect_valid = 1'b0; sb_en = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1 || out_pc !== 32'h102 || out_inst !== 32'h13 || rom_en !== 1'b0) begin
            errors++;
            $display("FAIL mis_entry: valid=%b fault=%b pc=%h inst=%h rom_en=%b expected 1/1/00000102/00000013/0",
                     out_valid, out_fault, out_pc, out_inst, rom_en);
        end
        for (int c = 0; c < 5; c++) begin
            tick;
            #1;
            checks++;
            if (out_valid !== 1'b0 || rom_en !== 1'b0 || out_fault !== 1'b0) begin
                errors++;
                $display("FAIL mis_halt: valid=%b rom_en=%b fault=%b expected 0/0/0", out_valid, rom_en, out_fault);
            end
        end
        sb_en = 1'b1;
        tick;
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick;
        redirect_valid = 1'b0;
        exp_q.push_back(32'h40); exp_q.push_back(32'h44);
`else
        tick;
        redirect_valid = 1'b0; out_ready = 1'b1;
        exp_q.push_back(32'h100); exp_q.push_back(32'h104);
        #1;
        checks++;
        if (rom_en !== 1'b1 || rom_addr !== 14'h40) begin
            errors++;
            $display("FAIL mis_mask: rom_en=%b addr=%h expected 1/0040", rom_en, rom_addr);
        end
`endif
        for (int c = 0; c < 10; c++) begin
            tick;
            #3;
            if (exp_q.size() == 0) break;
        end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mis_drain: %0d left expected 0", exp_q.size()); end
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_redirect_full;
        test_rst_mid;
        test_wrap;
        test_misalign;
        tick;
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
